// File: rtl/cr_kme_fifo_tx.sv
// KME FIFO write-side transmitter: checks SOT/EOT framing, tags packets and
// buffers beats in a 2-entry skid register ahead of a stall-style FIFO.
module cr_kme_fifo_tx #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         src_data,
    input  logic                      src_sot,
    input  logic                      src_eot,
    input  logic                      src_valid,
    output logic                      src_ready,
    output logic [TAG_W+2+DATA_W-1:0] fifo_in,
    output logic                      fifo_in_valid,
    input  logic                      fifo_in_stall,
    input  logic                      fifo_overflow,
    input  logic                      clear_err,
    output logic                      pkt_err,
    output logic                      ovf_sticky,
    output logic [CNT_W-1:0]          words_sent
);

    localparam int FW = TAG_W + 2 + DATA_W;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t            state, state_nxt;
    logic [TAG_W-1:0]  tag, tag_nxt, push_tag;
    logic [1:0]        cnt;
    logic [FW-1:0]     entry0, entry1, push_word;
    logic              accept, push, pop, err_set;

    assign src_ready     = (cnt < 2'd2);
    assign accept        = src_valid & src_ready;
    // Stall gates the write combinationally so a full FIFO is never written.
    assign fifo_in_valid = (cnt != 2'd0) & ~fifo_in_stall;
    assign pop           = fifo_in_valid;
    assign fifo_in       = entry0;
    assign push_word     = {push_tag, src_eot, src_sot, src_data};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:    if (src_sot && !src_eot) state_nxt = IN_PKT;
                IN_PKT:  state_nxt = src_eot ? IDLE : IN_PKT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        push     = 1'b0;
        push_tag = tag;
        err_set  = 1'b0;
        tag_nxt  = tag;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (src_sot) begin
                        push = 1'b1;
                        if (src_eot) tag_nxt = tag + TAG_W'(1);
                    end else begin
                        err_set = 1'b1;
                    end
                end
                IN_PKT: begin
                    push = 1'b1;
                    if (src_sot) begin
                        // Abandon the open packet: the new one takes the next tag.
                        push_tag = tag + TAG_W'(1);
                        err_set  = 1'b1;
                        tag_nxt  = src_eot ? tag + TAG_W'(2) : tag + TAG_W'(1);
                    end else if (src_eot) begin
                        tag_nxt = tag + TAG_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the two skid entries are few enough to reset, which keeps fifo_in at 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) entry0 <= push_word;
                    else             entry1 <= push_word;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                // Push with pop only happens at cnt==1: the new beat becomes head.
                2'b11:   entry0 <= push_word;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag        <= '0;
            pkt_err    <= 1'b0;
            ovf_sticky <= 1'b0;
            words_sent <= '0;
        end else begin
            tag     <= tag_nxt;
            pkt_err <= err_set;
            if (fifo_overflow)  ovf_sticky <= 1'b1;
            else if (clear_err) ovf_sticky <= 1'b0;
            if (pop && (words_sent != {CNT_W{1'b1}}))
                words_sent <= words_sent + CNT_W'(1);
        end
    end

endmodule
